uart_tx_arbiter: RTL and testbench

//   Shares one uart_tx transmitter between NUM_REQ byte sources using round-robin arbitration.

---
 rtl/uart_tx_arbiter.sv | 79 +++++++
 tb/tb_uart_tx_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among NUM_REQ byte sources
//   clk, reset_in           clock, synchronous active-high reset
//   req_valid/req_data      per-requester byte offers, slice i = req_data[i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready               one-hot accept, combinational, only in IDLE
//   tx_start/tx_din         to uart_tx: one-cycle start pulse and registered byte
//   tx_done_tick            from uart_tx: byte finished
//   busy/grant_id           not idle / owner of the byte in flight
//   protocol_err            sticky: tx_done_tick seen outside WAIT
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          reset_in,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_din,
  input  logic                          tx_done_tick,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          protocol_err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;
  state_t        state;
  logic [IW-1:0] rr_ptr, g;
  logic [IW:0]   j;
  logic          any;
  logic [GW-1:0] gap_cnt;
  // Scan from the far end back toward rr_ptr so the last hit is the first valid after rr_ptr;
  // the one extra bit on j keeps the wrapped index below NUM_REQ for any requester count.
  always_comb begin
    g = '0;
    any = 1'b0;
    j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = {1'b0, rr_ptr} + (IW+1)'(k);
      j = j >= (IW+1)'(NUM_REQ) ? j - (IW+1)'(NUM_REQ) : j;
      if (req_valid[j[IW-1:0]]) begin
        g = j[IW-1:0];
        any = 1'b1;
      end
    end
  end
  assign req_ready = (state == IDLE && any) ? NUM_REQ'(1) << g : '0;
  assign tx_start  = state == START;
  assign busy      = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset_in) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      tx_din       <= '0;
      grant_id     <= '0;
      gap_cnt      <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (tx_done_tick && state != WAIT) protocol_err <= 1'b1;
      case (state)
        IDLE: if (any) begin
          tx_din   <= req_data[g*DATA_WIDTH +: DATA_WIDTH];
          grant_id <= g;
          rr_ptr   <= g == IW'(NUM_REQ - 1) ? '0 : g + 1'b1;
          state    <= START;
        end
        START: state <= WAIT;
        WAIT: if (tx_done_tick) state <= GAP_CYCLES > 0 ? GAP : IDLE;
        GAP: begin
          gap_cnt <= gap_cnt == GW'(GAP_CYCLES - 1) ? '0 : gap_cnt + 1'b1;
          if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table, fairness sequence and randomized model check of uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int N = 4, W = 8, GAP = 3;
  logic             clk = 1'b0;
  logic             reset_in, tx_start, tx_done_tick, busy, protocol_err;
  logic [N-1:0]     req_valid, req_ready;
  logic [N*W-1:0]   req_data;
  logic [W-1:0]     tx_din;
  logic [1:0]       grant_id;
  logic [16:0]      outvec;
  int               checks = 0, passed = 0, cyc = 0;
  int               m_ptr, m_idle_at, m_start, m_gid, e_g;
  bit               m_owned, m_err, e_idle, e_found, e_start, e_busy;
  logic [7:0]       m_din;
  logic [N-1:0]     e_ready;
  typedef struct packed {
    logic [3:0] v;
    logic       dn;
    logic       r;
    logic [3:0] rdy;
    logic       st;
    logic       bs;
    logic [7:0] din;
    logic [1:0] gid;
    logic       err;
  } vec_t;
  vec_t tbl [25];

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset_in(reset_in), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_din(tx_din), .tx_done_tick(tx_done_tick),
    .busy(busy), .grant_id(grant_id), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;
  assign outvec = {req_ready, tx_start, busy, tx_din, grant_id, protocol_err};

  // Reference: the arbiter is free once no byte is owned and the post-done gap has elapsed;
  // tx_start is expected exactly one cycle after an accept.
  function automatic void model_eval();
    e_idle = !m_owned && cyc >= m_idle_at;
    e_found = 0;
    e_g = 0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (!e_found && req_valid[i]) begin
        e_found = 1;
        e_g = i;
      end
    end
    e_ready = (e_idle && e_found) ? 4'(1 << e_g) : 4'b0;
    e_start = cyc == m_start;
    e_busy = !e_idle;
  endfunction

  function automatic void model_update();
    if (reset_in) begin
      m_owned = 0; m_idle_at = 0; m_start = -1; m_ptr = 0; m_din = 0; m_gid = 0; m_err = 0;
    end else begin
      if (tx_done_tick) begin
        if (m_owned && cyc > m_start) begin
          m_owned = 0;
          m_idle_at = cyc + 1 + GAP;
        end else m_err = 1;
      end
      if (e_idle && e_found) begin
        m_owned = 1;
        m_start = cyc + 1;
        m_din = req_data[e_g*W +: W];
        m_gid = e_g;
        m_ptr = (e_g + 1) % N;
      end
    end
    cyc++;
  endfunction

  function automatic logic [16:0] expv();
    return {e_ready, e_start, e_busy, m_din, m_gid[1:0], m_err};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act === exp_v) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic dn, input logic r);
    req_valid = v;
    req_data = d;
    tx_done_tick = dn;
    reset_in = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        dn, r;
    int          order[$];
    int          starts, dones, last_start;
    m_owned = 0; m_idle_at = 0; m_start = -1; m_ptr = 0; m_din = 0; m_gid = 0; m_err = 0;
    tbl[0]  = '{4'b0010, 0, 0, 4'b0010, 0, 0, 8'h00, 0, 0};
    tbl[1]  = '{4'b0000, 0, 0, 4'b0000, 1, 1, 8'hA5, 1, 0};
    tbl[2]  = '{4'b0000, 0, 0, 4'b0000, 0, 1, 8'hA5, 1, 0};
    tbl[3]  = '{4'b0000, 1, 0, 4'b0000, 0, 1, 8'hA5, 1, 0};
    tbl[4]  = '{4'b0001, 0, 0, 4'b0000, 0, 1, 8'hA5, 1, 0};
    tbl[5]  = '{4'b0001, 0, 0, 4'b0000, 0, 1, 8'hA5, 1, 0};
    tbl[6]  = '{4'b0001, 0, 0, 4'b0000, 0, 1, 8'hA5, 1, 0};
    tbl[7]  = '{4'b0001, 0, 0, 4'b0001, 0, 0, 8'hA5, 1, 0};
    tbl[8]  = '{4'b0000, 0, 0, 4'b0000, 1, 1, 8'h11, 0, 0};
    tbl[9]  = '{4'b0000, 1, 0, 4'b0000, 0, 1, 8'h11, 0, 0};
    tbl[10] = '{4'b0000, 1, 0, 4'b0000, 0, 1, 8'h11, 0, 0};
    tbl[11] = '{4'b0000, 0, 0, 4'b0000, 0, 1, 8'h11, 0, 1};
    tbl[12] = '{4'b0000, 0, 0, 4'b0000, 0, 1, 8'h11, 0, 1};
    tbl[13] = '{4'b0000, 1, 0, 4'b0000, 0, 0, 8'h11, 0, 1};
    tbl[14] = '{4'b1100, 0, 0, 4'b0100, 0, 0, 8'h11, 0, 1};
    tbl[15] = '{4'b1100, 0, 0, 4'b0000, 1, 1, 8'h33, 2, 1};
    tbl[16] = '{4'b1100, 1, 0, 4'b0000, 0, 1, 8'h33, 2, 1};
    tbl[17] = '{4'b1100, 0, 0, 4'b0000, 0, 1, 8'h33, 2, 1};
    tbl[18] = '{4'b1100, 0, 0, 4'b0000, 0, 1, 8'h33, 2, 1};
    tbl[19] = '{4'b1100, 0, 0, 4'b0000, 0, 1, 8'h33, 2, 1};
    tbl[20] = '{4'b1100, 0, 0, 4'b1000, 0, 0, 8'h33, 2, 1};
    tbl[21] = '{4'b0100, 0, 0, 4'b0000, 1, 1, 8'h44, 3, 1};
    tbl[22] = '{4'b0100, 0, 1, 4'b0000, 0, 1, 8'h44, 3, 1};
    tbl[23] = '{4'b0111, 0, 0, 4'b0001, 0, 0, 8'h00, 0, 0};
    tbl[24] = '{4'b0111, 0, 0, 4'b0000, 1, 1, 8'h11, 0, 0};
    repeat (2) begin
      drive(4'b0, 32'h0, 1'b0, 1'b1);
      model_eval();
      tick();
    end
    drive(4'b0, 32'h4433A511, 1'b0, 1'b0);
    model_eval();
    check("reset_state", outvec, 17'h0);
    tick();
    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].v, 32'h4433A511, tbl[i].dn, tbl[i].r);
      model_eval();
      check($sformatf("vec%0d", i), outvec,
            {tbl[i].rdy, tbl[i].st, tbl[i].bs, tbl[i].din, tbl[i].gid, tbl[i].err});
      tick();
    end
    drive(4'b0, 32'h0, 1'b0, 1'b1);
    model_eval();
    tick();
    d = $urandom;
    starts = 0;
    dones = 0;
    last_start = -10;
    for (int i = 0; i < 60; i++) begin
      dn = cyc == last_start + 2;
      drive(4'b1111, d, dn, 1'b0);
      model_eval();
      check("fair_model", outvec, expv());
      if (req_ready != 0) order.push_back($clog2(req_ready));
      if (tx_start) begin
        starts++;
        last_start = cyc;
      end
      if (dn) dones++;
      tick();
    end
    for (int k = 0; k < 5; k++) check($sformatf("grant_order%0d", k), k < order.size() ? order[k] : -1, k % 4);
    check("start_per_done", starts >= dones && starts <= dones + 1 && dones > 0, 1);
    for (int i = 0; i < 3000; i++) begin
      dn = (m_owned && cyc > m_start) ? ($urandom_range(3) == 0) : ($urandom_range(63) == 0);
      r = $urandom_range(199) == 0;
      drive(4'($urandom), $urandom, dn, r);
      model_eval();
      check("rand", outvec, expv());
      tick();
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
